// File: rtl/serial_cla_adder_if.sv
// Handshake and operand/result bundle for serial_cla_adder.
// master drives the request side, slave (the adder) drives results.
interface serial_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_cla_adder.sv
// Serial adder: one 4-bit carry-lookahead slice reused over WIDTH/4 cycles.
// Optional signed overflow flag enabled by defining SERIAL_CLA_OVF_EN.
module serial_cla_adder #(
    parameter int WIDTH = 16
) (
    input logic               clk,
    input logic               rst,
    serial_cla_adder_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    if ((WIDTH % 4 != 0) || (WIDTH < 8)) begin : g_bad_width
        $error("serial_cla_adder: WIDTH must be a multiple of 4 and >= 8");
    end

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic [IW-1:0]    idx;
    logic             last;

    logic [3:0] na;
    logic [3:0] nb;
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    logic [3:0] s;

    assign last = (idx == IW'(NIB - 1));

    // Lookahead slice over the nibble currently selected by idx.
    always_comb begin
        na   = a_q[4*idx +: 4];
        nb   = b_q[4*idx +: 4];
        g    = na & nb;
        p    = na ^ nb;
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s    = p ^ c[3:0];
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = ADD;
            ADD:     if (last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

`ifdef SERIAL_CLA_OVF_EN
    logic ovf_q;

    // Signed overflow from the top slice, captured with cout.
    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else if ((state == ADD) && last) ovf_q <= c[4] ^ c[3];
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    // Operand capture, per-nibble result write-back and carry chaining.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= bus.cin;
                        idx     <= '0;
                    end
                end
                ADD: begin
                    sum_q[4*idx +: 4] <= s;
                    carry_q           <= c[4];
                    idx               <= idx + 1'b1;
                    if (last) cout_q <= c[4];
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule
